clk_en_ctrl: RTL and testbench
==============================

CLK_EN_CTRL -- requirements
Module: clk_en_ctrl

Interface
REQ-001 Parameters SHALL be:
- CNT_W, default 4, width of the divide ratio and phase counter.
- DIV_RST, default 3, ratio loaded at reset.

REQ-002 Ports SHALL be:
- clk_i  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_div  in  CNT_W  requested ratio; enable period = cfg_div+1 cycles.
- cfg_valid  in  1  ratio-change request.
- cfg_ready  out  1  ratio change accepted this cycle if cfg_valid is also high.
- run_i  in  1  level; free-run request.
- step_i  in  1  single-cycle pulse; single-period request.
- clk_en_o  out  1  registered one-cycle clock-enable pulse for the datapath.
- phase_o  out  CNT_W  current phase counter value.
- busy_o  out  1  high in RUN or STEP.

Function
REQ-003 The block SHALL implement states HALT, RUN and STEP, and SHALL hold a registered ratio div_q and a phase counter cnt.
REQ-004 In HALT, cnt SHALL hold 0 and clk_en_o SHALL be 0.
REQ-005 In RUN or STEP, cnt SHALL increment each cycle; when cnt==div_q, cnt SHALL wrap to 0 and clk_en_o SHALL be 1 in the following cycle only.
- Result: period is div_q+1 cycles.
- With div_q==0, clk_en_o SHALL stay high continuously from the second RUN cycle.
REQ-006 The wrap comparison SHALL be on CNT_W bits; cnt SHALL never exceed div_q.
REQ-007 State transitions SHALL be:
- HALT->RUN when run_i==1.
- HALT->STEP when step_i==1 and run_i==0; run_i has priority on simultaneous assertion.
REQ-008 STEP SHALL complete exactly one period (one clk_en_o pulse) and then return to HALT. step_i SHALL be ignored outside HALT.
REQ-009 In RUN with run_i==0, the block SHALL finish the current period, issuing its pulse, and enter HALT at the wrap. If run_i re-asserts before the wrap, the block SHALL stay in RUN.
REQ-010 cfg_ready SHALL be 1 in HALT, or in RUN/STEP when cnt==div_q; otherwise 0.
REQ-011 On cfg_valid&&cfg_ready, div_q SHALL load cfg_div and cnt SHALL be 0 next cycle. The wrap pulse of the completing period SHALL still be issued, and the next period SHALL use the new ratio.
REQ-012 busy_o SHALL equal (state!=HALT); phase_o SHALL equal cnt.

Reset
REQ-013 While rst_n==0, independent of clk_i:
- state=HALT, div_q=DIV_RST, cnt=0.
- clk_en_o=0, busy_o=0, phase_o=0, cfg_ready=1.
REQ-014 Reset asserted mid-period SHALL abort the period with no further clk_en_o pulse. Operation SHALL resume only on a new run_i or step_i after release.

Configuration
REQ-015 With CLK_EN_CTRL_STATS_EN defined:
- The block SHALL add output en_count_o (16 bits), incremented once per clk_en_o pulse.
- en_count_o SHALL wrap from 16'hFFFF to 0 and SHALL reset to 0.
REQ-016 Without CLK_EN_CTRL_STATS_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-017 Package clk_en_pkg SHALL hold the state type (HALT, RUN, STEP) and the default DIV_RST constant.
REQ-018 The phase counter with wrap flag and synchronous load SHALL be sub-module clk_en_counter. The FSM, handshake and output registers SHALL reside in clk_en_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then run_i=1 with DIV_RST=3 -> clk_en_o pulses every 4 cycles; phase_o cycles 0,1,2,3.
- In HALT: cfg_div=0 with cfg_valid=1, then run_i=1 -> cfg_ready=1 at the request; clk_en_o continuously 1 after the first RUN cycle.
- In RUN at div 3, cfg_div=1 with cfg_valid held from phase 1 -> accepted at phase 3 only; pending pulse issued; thereafter pulses every 2 cycles.
- In HALT, step_i pulse with div 2 -> exactly one clk_en_o pulse 3 cycles later; busy_o high 3 cycles; back to HALT. Second step_i during STEP is ignored.
- run_i dropped at phase 1 (div 3) -> two more cycles, one final pulse, then HALT. rst_n low at phase 2 -> immediate HALT, no pulse.
- STATS build: 70000 pulses at div 0 -> en_count_o == 70000 mod 65536 == 4464.

Source files
------------

// File: rtl/clk_en_pkg.sv
// Shared types and constants for the clock-enable controller.
//   clk_en_state_e  : controller state (halt, free-run, single-period step)
//   DIV_RST_DEFAULT : divide ratio loaded at reset when no override is given
package clk_en_pkg;

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } clk_en_state_e;

    localparam int unsigned DIV_RST_DEFAULT = 3;

endpackage

// File: rtl/clk_en_counter.sv
// Phase counter for the clock-enable controller.
// Counts 0..i_limit while i_en is high, wrapping to 0 after i_limit.
// A synchronous load (i_load) forces the count to 0 and wins over counting.
// Ports:
//   clk_i, rst_n : clock, asynchronous active-low reset
//   i_en         : count this cycle
//   i_load       : synchronous clear to 0
//   i_limit      : terminal count (the divide ratio)
//   o_cnt        : current count
//   o_wrap       : counting and at terminal count this cycle
module clk_en_counter
    import clk_en_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    assign o_wrap = i_en && (r_cnt == i_limit);
    assign o_cnt  = r_cnt;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_load) begin
            w_cnt_d = '0;
        end else if (i_en) begin
            w_cnt_d = o_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

// File: rtl/clk_en_ctrl.sv
// Clock-enable controller: issues a registered one-cycle enable pulse every
// div+1 cycles while running, or for exactly one period on a step request.
// Optional feature macro: CLK_EN_CTRL_STATS_EN adds a 16-bit pulse counter.
// Ports:
//   clk_i, rst_n         : clock, asynchronous active-low reset
//   cfg_div/cfg_valid    : requested ratio and change request
//   cfg_ready            : ratio change accepted if cfg_valid is high
//   run_i                : free-run request (level)
//   step_i               : single-period request (pulse, honoured in halt only)
//   clk_en_o             : enable pulse, one cycle after each period wrap
//   phase_o              : current phase count
//   busy_o               : running or stepping
//   en_count_o           : (stats build only) number of enable pulses, mod 2^16
module clk_en_ctrl
    import clk_en_pkg::*;
#(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DIV_RST = DIV_RST_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             run_i,
    input  logic             step_i,
    output logic             clk_en_o,
    output logic [CNT_W-1:0] phase_o,
    output logic             busy_o
`ifdef CLK_EN_CTRL_STATS_EN
    ,
    output logic [15:0]      en_count_o
`endif
);

    clk_en_state_e    r_state;
    clk_en_state_e    w_state_d;
    logic [CNT_W-1:0] r_div;
    logic             r_clk_en;
    logic             w_active;
    logic             w_wrap;
    logic             w_cfg_load;
    logic [CNT_W-1:0] w_cnt;

    assign w_active   = (r_state != StHalt);
    // Ratio changes only between periods, so cnt can never exceed div.
    assign cfg_ready  = !w_active || w_wrap;
    assign w_cfg_load = cfg_valid && cfg_ready;

    clk_en_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .i_en    (w_active),
        .i_load  (!w_active || w_cfg_load),
        .i_limit (r_div),
        .o_cnt   (w_cnt),
        .o_wrap  (w_wrap)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StHalt: begin
                if (run_i) begin
                    w_state_d = StRun;
                end else if (step_i) begin
                    w_state_d = StStep;
                end
            end
            // Dropping run_i lets the current period finish before halting.
            StRun: begin
                if (w_wrap && !run_i) begin
                    w_state_d = StHalt;
                end
            end
            StStep: begin
                if (w_wrap) begin
                    w_state_d = StHalt;
                end
            end
            default: w_state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StHalt;
            r_div    <= CNT_W'(DIV_RST);
            r_clk_en <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_clk_en <= w_wrap;
            if (w_cfg_load) begin
                r_div <= cfg_div;
            end
        end
    end

    assign clk_en_o = r_clk_en;
    assign phase_o  = w_cnt;
    assign busy_o   = w_active;

`ifdef CLK_EN_CTRL_STATS_EN
    logic [15:0] r_en_count;

    // Counts on the edge that raises clk_en_o, so it tracks pulses seen so far.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_en_count <= '0;
        end else if (w_wrap) begin
            r_en_count <= r_en_count + 16'd1;
        end
    end

    assign en_count_o = r_en_count;
`endif

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Self-checking bench for clk_en_ctrl: directed scenarios followed by random
// stimulus, all compared against a period-level behavioural model.
module tb_clk_en_ctrl;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             run_i = 1'b0;
    logic             step_i = 1'b0;
    logic             clk_en_o;
    logic [CNT_W-1:0] phase_o;
    logic             busy_o;
`ifdef CLK_EN_CTRL_STATS_EN
    logic [15:0]      en_count_o;
`endif

    always #5 clk_i = ~clk_i;

    clk_en_ctrl #(
        .CNT_W   (CNT_W),
        .DIV_RST (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .cfg_div    (cfg_div),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .run_i      (run_i),
        .step_i     (step_i),
        .clk_en_o   (clk_en_o),
        .phase_o    (phase_o),
`ifdef CLK_EN_CTRL_STATS_EN
        .en_count_o (en_count_o),
`endif
        .busy_o     (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = halted, 1 = free running, 2 = one period only.
    // A period lasts div+1 cycles; the enable fires in the cycle after it ends.
    int m_mode, m_pos, m_div, m_en, m_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_pos = 0; m_div = 3; m_en = 0; m_pulses = 0;
    endfunction

    // Advance the model by one clock edge using the inputs present now.
    function automatic void model_edge();
        bit period_done;
        bit may_reconfig;
        if (!rst_n) begin
            model_reset();
            return;
        end
        period_done  = (m_mode != 0) && (m_pos == m_div);
        may_reconfig = (m_mode == 0) || period_done;
        m_en = period_done;
        if (period_done) m_pulses = (m_pulses + 1) % 65536;
        if (m_mode == 0) begin
            m_pos  = 0;
            m_mode = run_i ? 1 : (step_i ? 2 : 0);
        end else begin
            m_pos = period_done ? 0 : m_pos + 1;
            if (period_done && (m_mode == 2 || !run_i)) m_mode = 0;
        end
        if (cfg_valid && may_reconfig) begin
            m_div = int'(cfg_div);
            m_pos = 0;
        end
    endfunction

    task automatic check_model();
        chk("clk_en", clk_en_o, m_en);
        chk("phase", phase_o, m_pos);
        chk("busy", busy_o, m_mode != 0);
        chk("cfg_ready", cfg_ready, (m_mode == 0) || (m_pos == m_div));
`ifdef CLK_EN_CTRL_STATS_EN
        chk("en_count", en_count_o, m_pulses);
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_i);
        #1;
        check_model();
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_clk_en", clk_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_phase", phase_o, 0);
        chk("rst_ready", cfg_ready, 1);
    endtask

    task automatic set_div_in_halt(input int d);
        cfg_div = CNT_W'(d);
        cfg_valid = 1'b1;
        chk("halt_ready", cfg_ready, 1);
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state
        #3;
        chk("init_clk_en", clk_en_o, 0);
        chk("init_busy", busy_o, 0);
        chk("init_phase", phase_o, 0);
        chk("init_ready", cfg_ready, 1);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Free run at reset ratio 3: period 4, phase 0..3
        run_i = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cycle();
            chk("run3_phase", phase_o, k % 4);
            chk("run3_en", clk_en_o, (k > 0) && (k % 4 == 0));
        end
        // Drop run at phase 1: phases 2, 3, then final pulse and halt
        run_i = 1'b0;
        cycle(); chk("drop_p2", phase_o, 2); chk("drop_busy2", busy_o, 1);
        cycle(); chk("drop_p3", phase_o, 3); chk("drop_en3", clk_en_o, 0);
        cycle(); chk("drop_pulse", clk_en_o, 1); chk("drop_halt", busy_o, 0);
        cycle(); chk("drop_after", clk_en_o, 0);

        // Ratio 0: enable continuously high from the second run cycle
        set_div_in_halt(0);
        run_i = 1'b1;
        cycle(); chk("div0_first", clk_en_o, 0); chk("div0_busy", busy_o, 1);
        for (int k = 0; k < 6; k++) begin
            cycle(); chk("div0_en", clk_en_o, 1);
        end
        run_i = 1'b0;
        cycle(); chk("div0_stop_en", clk_en_o, 1); chk("div0_stop_busy", busy_o, 0);
        cycle(); chk("div0_idle", clk_en_o, 0);

        // Ratio change requested mid-period is held off until the wrap
        set_div_in_halt(3);
        run_i = 1'b1;
        cycle(); cycle();
        cfg_div = 4'd1;
        cfg_valid = 1'b1;
        chk("chg_ready_p1", cfg_ready, 0);
        cycle(); chk("chg_ready_p2", cfg_ready, 0);
        cycle(); chk("chg_ready_p3", cfg_ready, 1);
        cycle(); chk("chg_pulse", clk_en_o, 1); chk("chg_p0", phase_o, 0);
        cfg_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle(); chk("div1_en", clk_en_o, (k % 2 == 0));
        end
        run_i = 1'b0;
        cycle(); cycle(); cycle();
        chk("div1_halted", busy_o, 0);

        // Single step at ratio 2; a second step while stepping is ignored
        set_div_in_halt(2);
        step_i = 1'b1;
        cycle(); chk("step_busy0", busy_o, 1); chk("step_en0", clk_en_o, 0);
        cycle(); chk("step_busy1", busy_o, 1); chk("step_p1", phase_o, 1);
        step_i = 1'b0;
        cycle(); chk("step_busy2", busy_o, 1); chk("step_en2", clk_en_o, 0);
        cycle(); chk("step_pulse", clk_en_o, 1); chk("step_halt", busy_o, 0);
        cycle(); chk("step_after", clk_en_o, 0);
        cycle(); chk("step_ignored", busy_o, 0);

        // Reset mid-period aborts without a pulse; no restart without a request
        async_reset();
        cycle();
        rst_n = 1'b1;
        set_div_in_halt(3);
        run_i = 1'b1;
        cycle(); cycle(); cycle();
        chk("rstmid_p2", phase_o, 2);
        run_i = 1'b0;
        async_reset();
        cycle(); cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle(); chk("rstmid_no_pulse", clk_en_o, 0);
        end

        // Random stimulus against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) run_i = ~run_i;
            step_i    = ($urandom_range(0, 7) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = CNT_W'($urandom_range(0, 5));
            rst_n     = ($urandom_range(0, 79) != 0);
            cycle();
        end
        rst_n = 1'b1; run_i = 1'b0; step_i = 1'b0; cfg_valid = 1'b0;

`ifdef CLK_EN_CTRL_STATS_EN
        // 70000 pulses at ratio 0 wrap the 16-bit pulse counter
        async_reset();
        cycle();
        rst_n = 1'b1;
        set_div_in_halt(0);
        run_i = 1'b1;
        cycle();
        repeat (70000) @(posedge clk_i);
        #1;
        chk("stats_wrap", en_count_o, 16'd4464);
        run_i = 1'b0;
        async_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
